// File: rtl/mem_accel_bus_port.sv
// MEM-stage bus port: D-cache refill/writeback has priority, MMIO accelerator accesses
// run through a small FSM. Accelerator load results are registered into the MEM/WB boundary.
module mem_accel_bus_port #(
    parameter int unsigned          NUM_CH   = 2,
    parameter int unsigned          CH_W     = $clog2(NUM_CH > 1 ? NUM_CH : 2),
    parameter int unsigned          DATA_W   = 128,
    parameter int unsigned          TIMEOUT  = 1023,
    parameter logic [NUM_CH*32-1:0] CH_BASE  = {32'h4000_1000, 32'h4000_0000},
    parameter logic [31:0]          ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enable_i,
    input  logic              flush_i,
    input  logic              acc_valid_i,
    input  logic [CH_W-1:0]   acc_ch_i,
    input  logic [2:0]        acc_op_i,
    input  logic              acc_load_i,
    input  logic [31:0]       acc_wdata_i,
    input  logic              cache_req_valid_i,
    input  logic [31:0]       cache_req_addr_i,
    input  logic              cache_req_we_i,
    input  logic [DATA_W-1:0] cache_req_wdata_i,
    output logic              cache_gnt_o,
    output logic [31:0]       addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic              cs_o,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              rvalid_i,
    output logic              stall_o,
    output logic [31:0]       rsp_data_o,
    output logic              rsp_valid_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StWrite,
        StErrc,
        StFin,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        cap_q;
    logic               err_q;
    logic               kill_q;

    logic               accept;
    logic               bad_ch;
    logic               timeout_hit;
    logic               leaving_result;
    logic [31:0]        base;
    logic [31:0]        acc_addr;

    assign accept      = (state_q == StIdle) & acc_valid_i & ~cache_req_valid_i & ~flush_i;
    assign bad_ch      = ({1'b0, acc_ch_i} >= (CH_W + 1)'(NUM_CH));
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));
    assign acc_addr    = base + {27'b0, acc_op_i, 2'b00};
    assign leaving_result = (state_q == StFin) || (state_q == StErrc);

    always_comb begin
        base = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if ({1'b0, acc_ch_i} == (CH_W + 1)'(i)) begin
                base = CH_BASE[i*32 +: 32];
            end
        end
    end

    // Only the low word of the bus is meaningful for accelerator registers.
    generate
        if (DATA_W > 32) begin : g_unused_rdata
            logic unused_rdata_hi;
            assign unused_rdata_hi = ^rdata_i[DATA_W-1:32];
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        cache_gnt_o = 1'b0;
        cs_o        = 1'b0;
        we_o        = 1'b0;
        addr_o      = '0;
        wdata_o     = '0;
        stall_o     = 1'b0;
        case (state_q)
            StIdle: begin
                stall_o = acc_valid_i & ~flush_i;
                if (cache_req_valid_i) begin
                    cache_gnt_o = 1'b1;
                    cs_o        = 1'b1;
                    we_o        = cache_req_we_i;
                    addr_o      = cache_req_addr_i;
                    wdata_o     = cache_req_wdata_i;
                end
                if (accept) begin
                    if (bad_ch) begin
                        state_d = StErrc;
                    end else if (acc_load_i) begin
                        state_d = StRead;
                    end else begin
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                cs_o    = 1'b1;
                we_o    = 1'b1;
                addr_o  = addr_q;
                wdata_o = DATA_W'(wdata_q);
                state_d = enable_i ? StIdle : StDone;
            end
            StRead: begin
                cs_o    = 1'b1;
                addr_o  = addr_q;
                wdata_o = DATA_W'(wdata_q);
                stall_o = 1'b1;
                if (rvalid_i || timeout_hit) begin
                    state_d = StFin;
                end
            end
            StErrc, StFin, StDone: begin
                if (enable_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cap_q       <= '0;
            err_q       <= 1'b0;
            kill_q      <= 1'b0;
            rsp_data_o  <= '0;
            rsp_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= acc_addr;
                wdata_q <= acc_wdata_i;
                cnt_q   <= '0;
                err_q   <= bad_ch;
                cap_q   <= bad_ch ? ERR_DATA : 32'h0;
                kill_q  <= 1'b0;
            end
            if (state_q == StRead) begin
                if (rvalid_i) begin
                    cap_q <= rdata_i[31:0];
                    err_q <= 1'b0;
                end else if (timeout_hit) begin
                    cap_q <= ERR_DATA;
                    err_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
            // A flush while the load is outstanding lets the bus finish but drops the result.
            if ((state_q == StRead || leaving_result) && flush_i) begin
                kill_q <= 1'b1;
            end
            if (enable_i) begin
                if (!flush_i && leaving_result && !kill_q) begin
                    rsp_data_o  <= cap_q;
                    rsp_valid_o <= 1'b1;
                    err_o       <= err_q;
                end else begin
                    rsp_data_o  <= '0;
                    rsp_valid_o <= 1'b0;
                    err_o       <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_accel_bus_port.sv
// Scoreboard bench for mem_accel_bus_port: directed accesses push expected bus cycles and
// WB results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_accel_bus_port;

    localparam int DW = 128;
    localparam int TO = 1023;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          flush;
    logic          acc_valid;
    logic [1:0]    acc_ch;
    logic [2:0]    acc_op;
    logic          acc_load;
    logic [31:0]   acc_wdata;
    logic          cache_req_valid;
    logic [31:0]   cache_req_addr;
    logic          cache_req_we;
    logic [DW-1:0] cache_req_wdata;
    logic          cache_gnt_o;
    logic [31:0]   addr_o;
    logic [DW-1:0] wdata_o;
    logic          we_o;
    logic          cs_o;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          stall_o;
    logic [31:0]   rsp_data_o;
    logic          rsp_valid_o;
    logic          err_o;

    mem_accel_bus_port #(
        .NUM_CH  (2),
        .CH_W    (2),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .enable_i          (enable),
        .flush_i           (flush),
        .acc_valid_i       (acc_valid),
        .acc_ch_i          (acc_ch),
        .acc_op_i          (acc_op),
        .acc_load_i        (acc_load),
        .acc_wdata_i       (acc_wdata),
        .cache_req_valid_i (cache_req_valid),
        .cache_req_addr_i  (cache_req_addr),
        .cache_req_we_i    (cache_req_we),
        .cache_req_wdata_i (cache_req_wdata),
        .cache_gnt_o       (cache_gnt_o),
        .addr_o            (addr_o),
        .wdata_o           (wdata_o),
        .we_o              (we_o),
        .cs_o              (cs_o),
        .rdata_i           (rdata),
        .rvalid_i          (rvalid),
        .stall_o           (stall_o),
        .rsp_data_o        (rsp_data_o),
        .rsp_valid_o       (rsp_valid_o),
        .err_o             (err_o)
    );

    typedef struct packed {
        logic [31:0]   addr;
        logic          we;
        logic [DW-1:0] wdata;
    } bus_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int bus_events = 0;
    int stall_cycles = 0;
    bit prev_acc_cs = 1'b0;
    bit en_at_edge = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) en_at_edge <= enable & rst_n;

    always @(negedge clk) begin
        bus_t b;
        rsp_t r;
        if (stall_o) stall_cycles++;
        // A held READ cs counts once; every cache-granted cycle is its own access.
        if (cs_o && (cache_gnt_o || !prev_acc_cs)) begin
            bus_events++;
            if (bus_q.size() == 0) begin
                chk("bus_unexpected_cs", cs_o, 1'b0);
            end else begin
                b = bus_q.pop_front();
                chk("bus_addr", addr_o, b.addr);
                chk("bus_we", we_o, b.we);
                chk("bus_wdata", wdata_o, b.wdata);
            end
        end
        prev_acc_cs = cs_o & ~cache_gnt_o;
        if (en_at_edge && rsp_valid_o) begin
            if (rsp_q.size() == 0) begin
                chk("rsp_unexpected_valid", rsp_valid_o, 1'b0);
            end else begin
                r = rsp_q.pop_front();
                chk("rsp_data", rsp_data_o, r.data);
                chk("rsp_err", err_o, r.err);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable          = 1'b1;
        flush           = 1'b0;
        acc_valid       = 1'b0;
        acc_ch          = '0;
        acc_op          = '0;
        acc_load        = 1'b0;
        acc_wdata       = '0;
        cache_req_valid = 1'b0;
        cache_req_addr  = '0;
        cache_req_we    = 1'b0;
        cache_req_wdata = '0;
        rdata           = '0;
        rvalid          = 1'b0;
    endtask

    // Presents the access for one cycle (the accept edge), then withdraws it.
    task automatic issue(input logic [1:0] ch, input logic [2:0] op, input logic ld,
                         input logic [31:0] wd);
        acc_valid = 1'b1;
        acc_ch    = ch;
        acc_op    = op;
        acc_load  = ld;
        acc_wdata = wd;
        step();
        acc_valid = 1'b0;
    endtask

    // Runs READ until stall drops; rvalid pulses on the nwait-th READ cycle (0 = never).
    task automatic wait_read(input int nwait, input logic [31:0] rd);
        bit done = 1'b0;
        for (int k = 1; k <= TO + 20; k++) begin
            if (!stall_o) begin
                done = 1'b1;
                break;
            end
            rvalid = (k == nwait);
            rdata  = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, rd};
            step();
        end
        rvalid = 1'b0;
        if (!done) chk("read_bound", stall_o, 1'b0);
    endtask

    initial begin
        int s0;
        int e0;
        idle_inputs();
        enable = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        chk("rst_cs", cs_o, 1'b0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_wdata", wdata_o, 128'h0);
        chk("rst_stall", stall_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("rst_rsp_data", rsp_data_o, 32'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_gnt", cache_gnt_o, 1'b0);
        rst_n  = 1'b1;
        enable = 1'b1;
        step();

        // Store ch1 op3
        s0 = stall_cycles;
        e0 = bus_events;
        bus_q.push_back('{32'h4000_100C, 1'b1, 128'h1});
        issue(2'd1, 3'd3, 1'b0, 32'h1);
        step();
        step();
        chk("store_rsp_valid", rsp_valid_o, 1'b0);
        chk("store_stall_cycles", stall_cycles - s0, 1);
        chk("store_cs_pulses", bus_events - e0, 1);

        // Load ch0 op4, rvalid on 5th READ cycle
        s0 = stall_cycles;
        bus_q.push_back('{32'h4000_0010, 1'b0, 128'h0});
        rsp_q.push_back('{32'h0000_00A5, 1'b0});
        issue(2'd0, 3'd4, 1'b1, 32'h0);
        wait_read(5, 32'hA5);
        step();
        chk("load_stall_cycles", stall_cycles - s0, 6);
        chk("load_rsp_valid", rsp_valid_o, 1'b1);
        chk("load_rsp_data", rsp_data_o, 32'hA5);
        chk("load_err", err_o, 1'b0);
        step();

        // Load timeout on ch1 op7
        bus_q.push_back('{32'h4000_101C, 1'b0, 128'h0});
        rsp_q.push_back('{32'hDEAD_BEEF, 1'b1});
        issue(2'd1, 3'd7, 1'b1, 32'h0);
        wait_read(0, 32'h0);
        step();
        chk("timeout_rsp_data", rsp_data_o, 32'hDEAD_BEEF);
        chk("timeout_err", err_o, 1'b1);
        step();

        // Bad channel: error result without any bus cycle
        e0 = bus_events;
        rsp_q.push_back('{32'hDEAD_BEEF, 1'b1});
        issue(2'd2, 3'd1, 1'b1, 32'h0);
        wait_read(0, 32'h0);
        step();
        chk("badch_rsp_data", rsp_data_o, 32'hDEAD_BEEF);
        chk("badch_err", err_o, 1'b1);
        chk("badch_rsp_valid", rsp_valid_o, 1'b1);
        step();
        chk("badch_no_cs", bus_events - e0, 0);

        // Cache and accelerator together in IDLE: cache first
        bus_q.push_back('{32'h8000_0040, 1'b1, 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF});
        bus_q.push_back('{32'h4000_0008, 1'b1, 128'h55});
        cache_req_valid = 1'b1;
        cache_req_addr  = 32'h8000_0040;
        cache_req_we    = 1'b1;
        cache_req_wdata = 128'hCAFE_0000_0000_0000_0000_0000_0000_BEEF;
        acc_valid = 1'b1;
        acc_ch    = 2'd0;
        acc_op    = 3'd2;
        acc_load  = 1'b0;
        acc_wdata = 32'h55;
        #1;
        chk("both_gnt", cache_gnt_o, 1'b1);
        chk("both_stall", stall_o, 1'b1);
        step();
        cache_req_valid = 1'b0;
        step();
        acc_valid = 1'b0;
        chk("both_acc_we", we_o, 1'b1);
        step();
        step();

        // Cache request arriving during READ waits for IDLE
        bus_q.push_back('{32'h4000_1014, 1'b0, 128'h0});
        bus_q.push_back('{32'h8000_0080, 1'b0, 128'h0});
        rsp_q.push_back('{32'h1234_5678, 1'b0});
        issue(2'd1, 3'd5, 1'b1, 32'h0);
        cache_req_valid = 1'b1;
        cache_req_addr  = 32'h8000_0080;
        cache_req_we    = 1'b0;
        cache_req_wdata = '0;
        #1;
        chk("read_gnt_blocked", cache_gnt_o, 1'b0);
        chk("read_addr_held", addr_o, 32'h4000_1014);
        wait_read(3, 32'h1234_5678);
        chk("fin_gnt_blocked", cache_gnt_o, 1'b0);
        step();
        chk("idle_gnt", cache_gnt_o, 1'b1);
        chk("cache_wait_rsp_data", rsp_data_o, 32'h1234_5678);
        step();
        cache_req_valid = 1'b0;
        step();

        // Store with pipeline frozen three cycles: single cs pulse
        e0 = bus_events;
        enable = 1'b0;
        bus_q.push_back('{32'h4000_0004, 1'b1, 128'h77});
        issue(2'd0, 3'd1, 1'b0, 32'h77);
        step();
        chk("done_stall", stall_o, 1'b0);
        chk("done_cs", cs_o, 1'b0);
        step();
        step();
        enable = 1'b1;
        step();
        step();
        chk("frozen_store_pulses", bus_events - e0, 1);

        // Flush during READ: bus completes, result dropped
        bus_q.push_back('{32'h4000_0004, 1'b0, 128'h0});
        issue(2'd0, 3'd1, 1'b1, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_read(2, 32'hBB);
        step();
        chk("flush_rsp_valid", rsp_valid_o, 1'b0);
        chk("flush_rsp_data", rsp_data_o, 32'h0);
        step();

        // Reset in the middle of READ
        bus_q.push_back('{32'h4000_1000, 1'b0, 128'h0});
        issue(2'd1, 3'd0, 1'b1, 32'h0);
        step();
        chk("pre_reset_cs", cs_o, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_cs", cs_o, 1'b0);
        chk("mid_rst_stall", stall_o, 1'b0);
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 128'h99;
        step();
        rvalid = 1'b0;
        chk("post_rst_cs", cs_o, 1'b0);
        step();
        step();
        chk("post_rst_rsp_valid", rsp_valid_o, 1'b0);
        chk("post_rst_err", err_o, 1'b0);

        chk("bus_q_drained", bus_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
